// File: rtl/serial_mag_cmp_if.sv
// Handshake and operand/result bundle for serial_mag_cmp.
// The master requests a comparison; the slave returns a registered Gt/Eq/Lt result.
interface serial_mag_cmp_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             Gt;
    logic             Eq;
    logic             Lt;

    modport master (
        output start, a, b,
        input  busy, done, Gt, Eq, Lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, Gt, Eq, Lt
    );
endinterface

// File: rtl/serial_mag_cmp.sv
// Multi-cycle unsigned magnitude comparator: one 2-bit slice per clock, MSB slice first,
// stopping at the first unequal slice.
module serial_mag_cmp #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    serial_mag_cmp_if.slave bus
);
    localparam int unsigned S  = WIDTH / 2;
    localparam int unsigned KW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic {StIdle, StScan} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             done_q, done_d;

    logic [1:0] slice_a;
    logic [1:0] slice_b;

    assign slice_a = ra_q[{k_q, 1'b0} +: 2];
    assign slice_b = rb_q[{k_q, 1'b0} +: 2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    k_d     = KW'(S - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (slice_a > slice_b) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (slice_a < slice_b) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (k_q == '0) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy = (state_q == StScan);
    assign bus.done = done_q;
    assign bus.Gt   = gt_q;
    assign bus.Eq   = eq_q;
    assign bus.Lt   = lt_q;
endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp: directed test-plan cases plus randomized operands
// checked against an arithmetic reference model.
module tb_serial_mag_cmp;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned S     = WIDTH / 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_mag_cmp_if #(.WIDTH(WIDTH)) bus ();

    serial_mag_cmp #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slices examined = slices from the top down to and including the first unequal one.
    function automatic int slices_needed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        n = S;
        for (int i = S - 1; i >= 0; i--) begin
            if (((a >> (2 * i)) & 3) != ((b >> (2 * i)) & 3)) begin
                n = S - i;
                break;
            end
        end
        return n;
    endfunction

    // Call at a negedge. Drives operands, waits for done, checks latency/busy/result.
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit keep_start, input bit disturb, input string tag);
        int n;
        int c;
        int busy_cnt;
        bit got;
        n        = slices_needed(a, b);
        busy_cnt = 0;
        got      = 0;
        c        = 0;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) bus.start = 1'b0;
        @(negedge clk);
        while (c <= int'(S) + 3) begin
            if (bus.done) begin
                got = 1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (disturb) begin
                bus.a     = 8'hFF;
                bus.start = (c == 0 || c == 2);
            end
            @(negedge clk);
            c++;
        end
        if (disturb) bus.start = 1'b0;
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(c), 32'(n));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(n));
        check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
        check({tag, " Gt"}, 32'(bus.Gt), 32'(a > b));
        check({tag, " Eq"}, 32'(bus.Eq), 32'(a == b));
        check({tag, " Lt"}, 32'(bus.Lt), 32'(a < b));
        if (!keep_start) begin
            @(negedge clk);
            check({tag, " done_single"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               mode;
        int               extra_done;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", {29'd0, bus.Gt, bus.Eq, bus.Lt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_cmp(8'hB4, 8'h74, 1'b0, 1'b0, "b4_gt_74");
        run_cmp(8'h5A, 8'h5A, 1'b0, 1'b0, "5a_eq");
        run_cmp(8'h12, 8'h13, 1'b0, 1'b0, "12_lt_13");
        run_cmp(8'hFF, 8'h00, 1'b0, 1'b0, "ff_gt_00");

        // Operand isolation: a changes and start pulses while scanning.
        run_cmp(8'h40, 8'h40, 1'b0, 1'b1, "isolation");
        extra_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra_done++;
        end
        check("isolation no_extra_op", 32'(extra_done), 32'd0);
        check("isolation hold_eq", 32'(bus.Eq), 32'd1);

        // Reset mid-scan.
        bus.a     = 8'hAA;
        bus.b     = 8'hAA;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst result", {29'd0, bus.Gt, bus.Eq, bus.Lt}, 32'd0);
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check("midrst no_done", 32'(extra_done), 32'd0);
        run_cmp(8'h01, 8'h02, 1'b0, 1'b0, "after_rst_lt");

        // start held high: each op accepted at the edge ending the previous done cycle.
        run_cmp(8'hC0, 8'h00, 1'b1, 1'b0, "b2b_1_gt");
        run_cmp(8'h33, 8'h33, 1'b1, 1'b0, "b2b_2_eq");
        run_cmp(8'hC0, 8'h00, 1'b1, 1'b0, "b2b_3_gt");
        run_cmp(8'h33, 8'h33, 1'b0, 1'b0, "b2b_4_eq");

        for (int i = 0; i < 40; i++) begin
            ra   = WIDTH'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0) rb = WIDTH'($urandom);
            else if (mode == 1) rb = ra;
            else rb = ra ^ WIDTH'($urandom_range(1, 3) << (2 * $urandom_range(0, S - 1)));
            run_cmp(ra, rb, 1'b0, 1'b0, $sformatf("rand%0d_%02h_%02h", i, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
